vcr_ovc_ctrl_shared: RTL

Output-side VC controller for one router output port. It consumes the VC-allocator and switch-allocator grants for that port and tracks allocation state and downstream credits for `num_vcs` private and `num_vcs` shared output VCs. From that state it returns the `elig_*` and `free_*` vectors the allocator consumes. One instance sits per output port, between the allocator outputs and the downstream link's credit return.

---
 rtl/vcr_ovc_ctrl_shared.sv | 135 +++++++++++++
 1 files changed

// File: rtl/vcr_ovc_ctrl_shared.sv
// Output-side VC controller: tracks allocation state and downstream credits for a
// private and a shared bank of output VCs, and presents eligibility/free vectors.
module vcr_ovc_ctrl_shared #(
  parameter int unsigned num_vcs            = 4,
  parameter int unsigned buffer_size_per_vc = 8,
  parameter bit          atomic_vc_alloc    = 1'b1,
  localparam int unsigned VcW               = (num_vcs > 1) ? $clog2(num_vcs) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [num_vcs-1:0] vc_gnt_ovc,
  input  logic [num_vcs-1:0] vc_gnt_shared_ovc,
  input  logic               sw_gnt,
  input  logic [num_vcs-1:0] sw_sel_ovc,
  input  logic               sw_sel_shared,
  input  logic               flit_tail,
  input  logic               cred_valid,
  input  logic               cred_shared,
  input  logic [VcW-1:0]     cred_vc,
  output logic [num_vcs-1:0] elig_ovc,
  output logic [num_vcs-1:0] elig_shared_ovc,
  output logic [num_vcs-1:0] free_ovc,
  output logic [num_vcs-1:0] free_shared_ovc,
  output logic               shared_vc_active,
  output logic [2:0]         err
);

  localparam int unsigned     CntW = $clog2(buffer_size_per_vc + 1);
  localparam logic [CntW-1:0] Full = CntW'(buffer_size_per_vc);

  // StDrain is the allocated-with-tail-sent state, waiting for credits to return.
  typedef enum logic [1:0] {StIdle, StActive, StDrain} ovc_state_e;

  // Bank 0 is private, bank 1 is shared.
  ovc_state_e      state_q [2][num_vcs];
  ovc_state_e      state_d [2][num_vcs];
  logic [CntW-1:0] cnt_q   [2][num_vcs];
  logic [CntW-1:0] cnt_d   [2][num_vcs];
  logic [2:0]      err_q, err_d;

  // Next-state for every OVC's credit counter and allocation state, plus sticky errors.
  always_comb begin
    logic bk, gnt, dep, crd, rel;
    bk    = 1'b0;
    gnt   = 1'b0;
    dep   = 1'b0;
    crd   = 1'b0;
    rel   = 1'b0;
    err_d = err_q;
    for (int b = 0; b < 2; b++) begin
      for (int v = 0; v < int'(num_vcs); v++) begin
        bk  = (b == 1);
        gnt = bk ? vc_gnt_shared_ovc[v] : vc_gnt_ovc[v];
        dep = sw_gnt && sw_sel_ovc[v] && (sw_sel_shared == bk);
        crd = cred_valid && (cred_shared == bk) && (int'(cred_vc) == v);
        rel = 1'b0;

        cnt_d[b][v] = cnt_q[b][v];
        if (dep && !crd) begin
          if (cnt_q[b][v] == '0) err_d[1] = 1'b1;
          else                   cnt_d[b][v] = cnt_q[b][v] - CntW'(1);
        end else if (crd && !dep) begin
          if (cnt_q[b][v] == Full) err_d[0] = 1'b1;
          else                     cnt_d[b][v] = cnt_q[b][v] + CntW'(1);
        end

        state_d[b][v] = state_q[b][v];
        unique case (state_q[b][v])
          StIdle: begin
            if (gnt) state_d[b][v] = StActive;
          end
          StActive: begin
            if (dep && flit_tail) begin
              rel = 1'b1;
              // Skip the drain when every credit is already back after this cycle.
              state_d[b][v] = (atomic_vc_alloc && (cnt_d[b][v] != Full)) ? StDrain : StIdle;
            end
          end
          StDrain: begin
            if (cnt_d[b][v] == Full) begin
              rel           = 1'b1;
              state_d[b][v] = StIdle;
            end
          end
          default: state_d[b][v] = StIdle;
        endcase

        // A grant landing on the releasing cycle re-opens the OVC instead of erroring.
        if (gnt && (state_q[b][v] != StIdle)) begin
          if (rel) state_d[b][v] = StActive;
          else     err_d[2] = 1'b1;
        end
      end
    end
  end

  // State register; reset returns every OVC to idle with a full credit count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int v = 0; v < int'(num_vcs); v++) begin
          state_q[b][v] <= StIdle;
          cnt_q[b][v]   <= Full;
        end
      end
      err_q <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        for (int v = 0; v < int'(num_vcs); v++) begin
          state_q[b][v] <= state_d[b][v];
          cnt_q[b][v]   <= cnt_d[b][v];
        end
      end
      err_q <= err_d;
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    elig_ovc         = '0;
    elig_shared_ovc  = '0;
    free_ovc         = '0;
    free_shared_ovc  = '0;
    shared_vc_active = 1'b0;
    for (int v = 0; v < int'(num_vcs); v++) begin
      elig_ovc[v]        = (state_q[0][v] == StIdle);
      elig_shared_ovc[v] = (state_q[1][v] == StIdle);
      free_ovc[v]        = (cnt_q[0][v] != '0);
      free_shared_ovc[v] = (cnt_q[1][v] != '0);
      if (state_q[1][v] != StIdle) shared_vc_active = 1'b1;
    end
    err = err_q;
  end

endmodule
